mem_arbiter: RTL and testbench

// - Shares the single-port 256x16 instruction/data RAM between two requesters: port 0 = CPU, port 1 = loader/debug.
// - Sits between the requesters and the RAM.
// - Issues at most one RAM access per cycle, arbitrated round-robin.
// - Routes read data back to the originating port after a fixed read latency.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rd_pipe.sv | 33 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Lock support in the arbiter is enabled by defining MEM_ARB_LOCK_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RR0,
        RR1,
        LOCK0,
        LOCK1
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_rd_pipe.sv
// Fixed-latency read-tag shift register; the head tag lines up with RAM read data.
module mem_arb_rd_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_tag_valid,
    input  logic i_tag_port,
    output logic o_head_valid,
    output logic o_head_port
);

    rd_tag_t r_tags [RD_LAT];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            r_tags[0] <= '{valid: i_tag_valid, port: i_tag_port};
            for (int i = 1; i < RD_LAT; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    assign o_head_valid = r_tags[RD_LAT-1].valid;
    assign o_head_port  = r_tags[RD_LAT-1].port;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU (port 0) and loader (port 1).
// Define MEM_ARB_LOCK_EN to let a port hold the grant across beats via lock0/lock1.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    input  logic          i_lock0,
    input  logic          i_lock1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_rvalid0,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic          o_ram_w_en,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_w_data,
    input  logic [DW-1:0] i_ram_r_data
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_head_valid;
    logic       w_head_port;

`ifndef MEM_ARB_LOCK_EN
    logic w_unused_lock;
    assign w_unused_lock = i_lock0 ^ i_lock1;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            RR0: begin
                w_gnt0 = i_req0;
                w_gnt1 = i_req1 & ~i_req0;
            end
            RR1: begin
                w_gnt1 = i_req1;
                w_gnt0 = i_req0 & ~i_req1;
            end
            LOCK0:   w_gnt0 = i_req0;
            LOCK1:   w_gnt1 = i_req1;
            default: ;
        endcase
        if (i_rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    // A grant hands priority to the other port; no grant keeps the state (incl. locks).
    always_comb begin
        w_state_next = r_state;
        if (w_gnt0) begin
`ifdef MEM_ARB_LOCK_EN
            w_state_next = i_lock0 ? LOCK0 : RR1;
`else
            w_state_next = RR1;
`endif
        end else if (w_gnt1) begin
`ifdef MEM_ARB_LOCK_EN
            w_state_next = i_lock1 ? LOCK1 : RR0;
`else
            w_state_next = RR0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RR0;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign o_gnt0       = w_gnt0;
    assign o_gnt1       = w_gnt1;
    assign o_ram_addr   = w_gnt1 ? i_addr1 : i_addr0;
    assign o_ram_w_en   = (w_gnt0 & i_we0) | (w_gnt1 & i_we1);
    assign o_ram_w_data = w_gnt1 ? i_wdata1 : i_wdata0;

    mem_arb_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk        (i_clk),
        .i_clr        (i_rst),
        .i_tag_valid  ((w_gnt0 & ~i_we0) | (w_gnt1 & ~i_we1)),
        .i_tag_port   (w_gnt1 ? PORT_LDR : PORT_CPU),
        .o_head_valid (w_head_valid),
        .o_head_port  (w_head_port)
    );

    // Gating with reset keeps a read that was in flight at reset from ever reporting.
    assign o_rvalid0 = w_head_valid & ~i_rst & (w_head_port == PORT_CPU);
    assign o_rvalid1 = w_head_valid & ~i_rst & (w_head_port == PORT_LDR);
    assign o_rdata0  = i_ram_r_data;
    assign o_rdata1  = i_ram_r_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (RD_LAT=1 main instance, RD_LAT=3 latency instance).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, ram_w_en;
    logic [15:0] rdata0, rdata1, ram_w_data;
    logic [7:0]  ram_addr;
    logic [15:0] ram_r_data;

    logic        d3_req1;
    logic [7:0]  d3_addr1;
    logic        d3_gnt0, d3_gnt1, d3_rv0, d3_rv1, d3_w_en;
    logic [15:0] d3_rdata0, d3_rdata1, d3_w_data;
    logic [7:0]  d3_ram_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [15:0] ref_mem [256];
    bit   [15:0] mem     [256];
    bit          wr_valid[256];
    bit   [15:0] rd_q;

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // Behavioural RAM, one cycle read latency.
    always @(posedge clk) begin
        rd_q <= wr_valid[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
        if (ram_w_en) begin
            mem[ram_addr]      <= ram_w_data;
            wr_valid[ram_addr] <= 1'b1;
        end
    end
    assign ram_r_data = rd_q;

    mem_arbiter #(.AW(8), .DW(16), .RD_LAT(1)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_we0        (we0),
        .i_we1        (we1),
        .i_addr0      (addr0),
        .i_addr1      (addr1),
        .i_wdata0     (wdata0),
        .i_wdata1     (wdata1),
        .i_lock0      (lock0),
        .i_lock1      (lock1),
        .o_gnt0       (gnt0),
        .o_gnt1       (gnt1),
        .o_rvalid0    (rvalid0),
        .o_rvalid1    (rvalid1),
        .o_rdata0     (rdata0),
        .o_rdata1     (rdata1),
        .o_ram_w_en   (ram_w_en),
        .o_ram_addr   (ram_addr),
        .o_ram_w_data (ram_w_data),
        .i_ram_r_data (ram_r_data)
    );

    mem_arbiter #(.AW(8), .DW(16), .RD_LAT(3)) u_dut3 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0       (1'b0),
        .i_req1       (d3_req1),
        .i_we0        (1'b0),
        .i_we1        (1'b0),
        .i_addr0      (8'h00),
        .i_addr1      (d3_addr1),
        .i_wdata0     (16'h0000),
        .i_wdata1     (16'h0000),
        .i_lock0      (1'b0),
        .i_lock1      (1'b0),
        .o_gnt0       (d3_gnt0),
        .o_gnt1       (d3_gnt1),
        .o_rvalid0    (d3_rv0),
        .o_rvalid1    (d3_rv1),
        .o_rdata0     (d3_rdata0),
        .o_rdata1     (d3_rdata1),
        .o_ram_w_en   (d3_w_en),
        .o_ram_addr   (d3_ram_addr),
        .o_ram_w_data (d3_w_data),
        .i_ram_r_data (16'hC3A5)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: check read returns and the issued access, update scoreboard, advance.
    task automatic step(input logic eg0, input logic eg1, input string tag);
        logic        ewe;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic        erv0, erv1;
        exp_t        e;
        #1;
        if (rst) sb.delete();
        erv0 = 1'b0;
        erv1 = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            erv0 = (e.port == 1'b0);
            erv1 = (e.port == 1'b1);
            if (e.port) chk({tag, ":rdata1"}, rdata1, e.data);
            else        chk({tag, ":rdata0"}, rdata0, e.data);
        end
        chk({tag, ":rvalid0"}, {15'd0, rvalid0}, {15'd0, erv0});
        chk({tag, ":rvalid1"}, {15'd0, rvalid1}, {15'd0, erv1});
        chk({tag, ":gnt0"}, {15'd0, gnt0}, {15'd0, eg0});
        chk({tag, ":gnt1"}, {15'd0, gnt1}, {15'd0, eg1});
        ewe = (eg0 & we0) | (eg1 & we1);
        ea  = eg1 ? addr1 : addr0;
        ed  = eg1 ? wdata1 : wdata0;
        chk({tag, ":ram_w_en"}, {15'd0, ram_w_en}, {15'd0, ewe});
        chk({tag, ":ram_addr"}, {8'd0, ram_addr}, {8'd0, ea});
        if (ewe) begin
            chk({tag, ":ram_w_data"}, ram_w_data, ed);
            ref_mem[ea] = ed;
        end else if (eg0 | eg1) begin
            sb.push_back('{port: eg1, data: ref_mem[ea], due: cyc + 1});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        rst = 1'b1;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 16'h0000; wdata1 = 16'h0000;
        d3_req1 = 1'b0; d3_addr1 = 8'h00;

        step(1'b0, 1'b0, "rst_a");
        step(1'b0, 1'b0, "rst_b");

        // Port-0 read leaves priority with port 1; reset must both kill its return and restore RR0.
        rst = 1'b0; req0 = 1'b1; addr0 = 8'h3C;
        step(1'b1, 1'b0, "pre_rd0");
        rst = 1'b1; req0 = 1'b0; req1 = 1'b1; addr1 = 8'h33;
        step(1'b0, 1'b0, "rst_rd1_a");
        step(1'b0, 1'b0, "rst_rd1_b");

        rst = 1'b0; req0 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
        step(1'b1, 1'b0, "cont0");
        step(1'b0, 1'b1, "cont1");
        step(1'b1, 1'b0, "cont2");
        step(1'b0, 1'b1, "cont3");
        req0 = 1'b0; req1 = 1'b0;
        step(1'b0, 1'b0, "cont_drain");

        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h05; wdata1 = 16'hBEEF;
        step(1'b0, 1'b1, "wr1");
        req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; addr0 = 8'h05;
        step(1'b1, 1'b0, "rd0_after_wr");
        req0 = 1'b0;
        step(1'b0, 1'b0, "wr_rd_drain");

        req0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr0 = 8'h50 + 8'(i);
            step(1'b1, 1'b0, "single");
        end
        addr0 = 8'hFF;
        step(1'b1, 1'b0, "rd_wrap_ff");

        addr0 = 8'h30; req1 = 1'b1; addr1 = 8'h40; lock1 = 1'b1;
        step(1'b0, 1'b1, "lock_b0");
`ifdef MEM_ARB_LOCK_EN
        step(1'b0, 1'b1, "lock_b1");
`else
        step(1'b1, 1'b0, "lock_b1");
`endif
        lock1 = 1'b0;
        step(1'b0, 1'b1, "lock_b2");
        req1 = 1'b0;
        step(1'b1, 1'b0, "lock_after");
        req0 = 1'b0;
        step(1'b0, 1'b0, "lock_drain");

        d3_req1 = 1'b1; d3_addr1 = 8'h7F;
        #1;
        chk("d3_gnt1", {15'd0, d3_gnt1}, 16'd1);
        chk("d3_gnt0", {15'd0, d3_gnt0}, 16'd0);
        chk("d3_ram_addr", {8'd0, d3_ram_addr}, 16'h007F);
        step(1'b0, 1'b0, "d3_issue");
        d3_req1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("d3_rvalid1", {15'd0, d3_rv1}, {15'd0, (k == 3)});
            chk("d3_rvalid0", {15'd0, d3_rv0}, 16'd0);
            if (k == 3) chk("d3_rdata1", d3_rdata1, 16'hC3A5);
            step(1'b0, 1'b0, "d3_wait");
        end

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
